decoder_rr_arbiter: RTL and testbench
=====================================

// Module: decoder_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one one-hot decoder among up to 2**WIDTH requesters.
//  It picks one requester, drives its index on sel and holds the grant until the owner signals done.
//  sel connects straight to decoder.sel; the decoder output acts as the one-hot enable of the shared resource.
// PARAMETERS
//  WIDTH           5    select width; NREQ = 1<<WIDTH requesters (localparam)
//  TIMEOUT_CYCLES  64   max BUSY cycles before forced release (RR_TIMEOUT_EN only), >=1
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  req          in   NREQ   level request per requester; bit i = requester i
//  done         in   1      pulse from current owner: release grant
//  sel          out  WIDTH  index of granted requester; to decoder sel
//  grant_valid  out  1      sel valid, resource owned
//  busy         out  1      arbiter in BUSY state (== grant_valid)
//  timeout      out  1      1-cycle pulse on forced release; tied 0 without RR_TIMEOUT_EN
// BEHAVIOUR
//  - Reset (async, rst_n=0): sel=0, grant_valid=0, busy=0, timeout=0, state=IDLE.
//    Last-granted pointer last=NREQ-1, so requester 0 has top priority first.
//    Reset mid-grant drops the grant immediately, without waiting for a clock.
//  - FSM, 2 states:
//    IDLE: if |req at the edge -> BUSY; sel <= first set req bit searching last+1, last+2, ... mod NREQ.
//          grant_valid=1 from that edge (1-cycle latency req->grant). No req -> stay IDLE, sel holds.
//    BUSY: sel frozen; req changes are ignored, including the owner dropping its req.
//          done=1 -> IDLE, grant_valid<=0, last<=sel.
//  - No back-to-back grants: at least one IDLE cycle (grant_valid=0) between owners.
//    This is the decoder switch-over gap.
//  - done in IDLE is ignored. done and new req in the same cycle: release this edge, arbitrate next edge.
//  - Index wrap: search goes from NREQ-1 to 0.
//    Sole requester == last: it is re-granted after the idle gap (no starvation of a lone requester).
//  - Fairness: with all req held high, grants visit indices in order 0,1,..,NREQ-1,0,...
//  - sel is registered and glitch-free; outputs never depend combinationally on inputs.
//  - Priority search: combinational rotate + priority encode over NREQ bits.
//    This must close in one cycle at WIDTH<=5.
// CONFIGURATION
//  RR_TIMEOUT_EN defined:
//   - A counter clears on entry to BUSY and increments each BUSY cycle.
//   - When the count reaches TIMEOUT_CYCLES without done:
//     -> IDLE, grant_valid<=0, last<=sel, timeout=1 for exactly that cycle.
//   - done on the same cycle as expiry: normal release, timeout stays 0.
//  RR_TIMEOUT_EN undefined:
//   - No counter; the grant is held indefinitely until done; timeout driven constant 0.
// TESTING
//  1 Reset: rst_n=0 with req=all ones -> sel=0, grant_valid=0; release reset -> next edge sel=0, grant_valid=1.
//  2 Rotation: req=all ones, done pulsed 1 cycle after each grant
//    -> sel sequence 0,1,2,...,31,0 with one grant_valid=0 cycle between grants.
//  3 Sparse/wrap: last=30, req bits {3,17} -> grant 3; done -> grant 17; done, req={17} only -> grant 17 again.
//  4 Hold: owner 5 drops req mid-grant and req[9] rises -> sel stays 5 until done, then grant 9 after the gap.
//  5 Async reset mid-BUSY: rst_n low between edges -> grant_valid=0 and sel=0 immediately;
//    next grant starts search from 0.
//  6 RR_TIMEOUT_EN, TIMEOUT_CYCLES=4: grant 2, no done -> timeout=1 pulse after 4 BUSY cycles, grant_valid=0;
//    repeat with done on the 4th cycle -> timeout=0.
//  Every scenario: check decoder.out == 1<<sel whenever grant_valid=1.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one one-hot decoder among 1<<WIDTH requesters.
// Optional forced release after TIMEOUT_CYCLES busy cycles: define RR_TIMEOUT_EN.
module decoder_rr_arbiter #(
   parameter int WIDTH          = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [(1<<WIDTH)-1:0] req,
   input  logic                  done,
   output logic [WIDTH-1:0]      sel,
   output logic                  grant_valid,
   output logic                  busy,
   output logic                  timeout
);
   localparam int NREQ = 1 << WIDTH;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sel_q, sel_nx;
   logic [WIDTH-1:0] last_q, last_nx;
   logic [WIDTH-1:0] off, pick;
   logic [WIDTH:0]   start;
   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]  rot;
   logic             to_q, to_nx;

`ifdef RR_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] cnt_q;
   logic          expire;

   assign expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // Busy-cycle counter: zero in IDLE so it starts clean on each grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (state == IDLE)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + CW'(1);
   end
`endif

   // Rotate requests so bit 0 is the one just after last, then pick lowest
   always_comb begin
      start = {1'b0, last_q} + (WIDTH+1)'(1);
      dbl   = {req, req} >> start;
      rot   = dbl[NREQ-1:0];
      off   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i])
            off = WIDTH'(i);
      end
      pick = last_q + WIDTH'(1) + off;
   end

   // Next-state logic: grant from IDLE, release from BUSY
   always_comb begin
      state_nx = state;
      sel_nx   = sel_q;
      last_nx  = last_q;
      to_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_nx = BUSY;
               sel_nx   = pick;
            end
         end
         BUSY: begin
            if (done) begin
               state_nx = IDLE;
               last_nx  = sel_q;
            end
`ifdef RR_TIMEOUT_EN
            else if (expire) begin
               state_nx = IDLE;
               last_nx  = sel_q;
               to_nx    = 1'b1;
            end
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and registered outputs; reset drops the grant at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sel_q  <= '0;
         last_q <= WIDTH'(NREQ - 1);
         to_q   <= 1'b0;
      end else begin
         state  <= state_nx;
         sel_q  <= sel_nx;
         last_q <= last_nx;
         to_q   <= to_nx;
      end
   end

   assign sel         = sel_q;
   assign grant_valid = (state == BUSY);
   assign busy        = (state == BUSY);
`ifdef RR_TIMEOUT_EN
   assign timeout     = to_q;
`else
   assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter.
// Timeout scenario runs when RR_TIMEOUT_EN is defined.
module tb_decoder_rr_arbiter;
   localparam int WIDTH = 5;
   localparam int NREQ  = 1 << WIDTH;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NREQ-1:0] req;
   logic            done;
   logic [WIDTH-1:0] sel;
   logic            grant_valid;
   logic            busy;
   logic            timeout;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [NREQ-1:0] req;
      logic            done;
      int              exp_sel;
      logic            exp_gv;
   } vec_t;

   vec_t tbl [18];

   decoder_rr_arbiter #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done),
      .sel(sel), .grant_valid(grant_valid), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check(input string nm, input int es, input logic eg,
                        input logic et);
      logic [NREQ-1:0] dec, edec;
      dec  = grant_valid ? (NREQ'(1) << sel) : '0;
      edec = eg ? (NREQ'(1) << es) : '0;
      cmp({nm, ".gv"}, grant_valid, eg);
      cmp({nm, ".busy"}, busy, eg);
      cmp({nm, ".timeout"}, timeout, et);
      cmp({nm, ".sel"}, sel, es);
      cmp({nm, ".dec"}, dec, edec);
   endtask

   function automatic logic [NREQ-1:0] b(input int i);
      return NREQ'(1) << i;
   endfunction

   initial begin
      tbl[0]  = '{b(30),         1'b1,  0, 1'b0};
      tbl[1]  = '{b(30),         1'b0, 30, 1'b1};
      tbl[2]  = '{b(3) | b(17),  1'b1, 30, 1'b0};
      tbl[3]  = '{b(3) | b(17),  1'b0,  3, 1'b1};
      tbl[4]  = '{b(3) | b(17),  1'b0,  3, 1'b1};
      tbl[5]  = '{b(3) | b(17),  1'b1,  3, 1'b0};
      tbl[6]  = '{b(3) | b(17),  1'b0, 17, 1'b1};
      tbl[7]  = '{b(17),         1'b1, 17, 1'b0};
      tbl[8]  = '{b(17),         1'b0, 17, 1'b1};
      tbl[9]  = '{b(5),          1'b1, 17, 1'b0};
      tbl[10] = '{b(5),          1'b0,  5, 1'b1};
      tbl[11] = '{b(9),          1'b0,  5, 1'b1};
      tbl[12] = '{b(9),          1'b0,  5, 1'b1};
      tbl[13] = '{b(9),          1'b1,  5, 1'b0};
      tbl[14] = '{b(9),          1'b0,  9, 1'b1};
      tbl[15] = '{'0,            1'b1,  9, 1'b0};
      tbl[16] = '{'0,            1'b1,  9, 1'b0};
      tbl[17] = '{b(9),          1'b0,  9, 1'b1};

      // Reset with every requester asking
      rst_n = 1'b0;
      req   = '1;
      done  = 1'b0;
      #2;
      check("rst", 0, 1'b0, 1'b0);
      tick();
      tick();
      check("rst_hold", 0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      check("first_grant", 0, 1'b1, 1'b0);

      // Full rotation with all requests high
      for (int k = 0; k < NREQ; k++) begin
         done = 1'b1;
         tick();
         check($sformatf("rot_gap%0d", k), k, 1'b0, 1'b0);
         done = 1'b0;
         tick();
         check($sformatf("rot_grant%0d", k), (k + 1) % NREQ, 1'b1, 1'b0);
      end

      // Sparse, wrap, lone requester, hold, done in IDLE
      for (int i = 0; i < 18; i++) begin
         req  = tbl[i].req;
         done = tbl[i].done;
         tick();
         check($sformatf("vec%0d", i), tbl[i].exp_sel, tbl[i].exp_gv, 1'b0);
      end

      // Async reset between edges while owner 9 holds the grant
      req  = b(5) | b(20);
      done = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst", 0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b1;
      tick();
      check("post_rst_grant", 5, 1'b1, 1'b0);

      done = 1'b1;
      req  = '0;
      tick();
      check("release5", 5, 1'b0, 1'b0);
      done = 1'b0;
      req  = b(2);
      tick();
      check("grant2", 2, 1'b1, 1'b0);
      req = '0;

`ifdef RR_TIMEOUT_EN
      tick();
      tick();
      tick();
      check("busy4", 2, 1'b1, 1'b0);
      tick();
      check("to_pulse", 2, 1'b0, 1'b1);
      tick();
      check("to_clear", 2, 1'b0, 1'b0);
      req = b(2);
      tick();
      check("regrant2", 2, 1'b1, 1'b0);
      req = '0;
      tick();
      tick();
      tick();
      done = 1'b1;
      tick();
      check("done_at_expiry", 2, 1'b0, 1'b0);
      done = 1'b0;
`else
      for (int c = 0; c < 70; c++)
         tick();
      check("long_hold", 2, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      check("long_release", 2, 1'b0, 1'b0);
      done = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
